// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider / period-start tick generator.
// Ratio changes are shadowed and only applied when a new period begins.
module clk_div_prog #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_ratio
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act, act_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic             clk_n, tick_n;

  logic [CNT_W-1:0] cr, nxt, half, cnt_inc;
  logic             last, start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      act     <= DEF;
      shadow  <= DEF;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      act     <= act_n;
      shadow  <= shadow_n;
      clk_out <= clk_n;
      tick    <= tick_n;
    end
  end

  always_comb begin
    cr       = (div_ratio < TWO) ? TWO : div_ratio;
    // A load coinciding with a period start applies to that very period.
    nxt      = div_load ? cr : shadow;
    half     = act >> 1;
    cnt_inc  = cnt + ONE;
    last     = (cnt == (act - ONE));

    state_n  = state;
    cnt_n    = cnt;
    act_n    = act;
    shadow_n = nxt;
    clk_n    = clk_out;
    tick_n   = 1'b0;
    start    = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          start = 1'b1;
        end else begin
          cnt_n = '0;
          clk_n = 1'b0;
        end
      end
      RUN: begin
        if (!last) begin
          cnt_n = cnt_inc;
          clk_n = (cnt_inc < half);
        end else if (en) begin
          start = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          clk_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        clk_n   = 1'b0;
      end
    endcase

    if (start) begin
      state_n = RUN;
      cnt_n   = '0;
      act_n   = nxt;
      clk_n   = 1'b1;
      tick_n  = 1'b1;
    end
  end

  assign busy      = (state == RUN);
  assign cur_ratio = act;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform shape, ratio shadowing, stop/restart,
// ratio coercion, maximum ratio and asynchronous reset.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_ratio;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_ratio;

  int total = 0;
  int bad   = 0;

  clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_ratio (cur_ratio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step();
  endtask

  // Called at cnt=0 of a period; checks whole periods and returns at the next start.
  task automatic run_wave(input string tag, input int unsigned n, input int unsigned h,
                          input int unsigned periods);
    for (int unsigned p = 0; p < periods; p++) begin
      for (int unsigned i = 0; i < n; i++) begin
        check($sformatf("%s.clk_out[%0d]", tag, i), 32'(clk_out), 32'(i < h));
        check($sformatf("%s.tick[%0d]", tag, i), 32'(tick), 32'(i == 0));
        check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
        check($sformatf("%s.ratio[%0d]", tag, i), 32'(cur_ratio), 32'(n));
        step();
      end
    end
  endtask

  task automatic load_at(input logic [7:0] r);
    div_ratio = r;
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    div_ratio = '0;
    div_load  = 1'b0;
    skip(2);
    check("rst.clk_out", 32'(clk_out), 32'd0);
    check("rst.tick", 32'(tick), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ratio", 32'(cur_ratio), 32'd4);
    rst_n = 1'b1;
    step();
    check("idle.busy", 32'(busy), 32'd0);

    // 1: default divide-by-4, one-cycle start latency
    en = 1'b1;
    step();
    run_wave("div4", 4, 2, 2);

    // 2: load 5 at a period start, then 2
    skip(3);
    load_at(8'd5);
    run_wave("div5", 5, 2, 2);
    skip(4);
    load_at(8'd2);
    run_wave("div2", 2, 1, 3);

    // 3: back to 4, then load 6 mid-period at cnt=1
    step();
    load_at(8'd4);
    step();
    load_at(8'd6);
    check("mid.ratio_old", 32'(cur_ratio), 32'd4);
    check("mid.clk_out", 32'(clk_out), 32'd0);
    step();
    check("mid.ratio_old3", 32'(cur_ratio), 32'd4);
    check("mid.tick", 32'(tick), 32'd0);
    step();
    run_wave("div6", 6, 3, 2);

    // 4: N=8, drop en at cnt=0, period completes, then idle
    skip(5);
    load_at(8'd8);
    en = 1'b0;
    run_wave("stop8", 8, 4, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      check("stopped.busy", 32'(busy), 32'd0);
      check("stopped.clk_out", 32'(clk_out), 32'd0);
      check("stopped.tick", 32'(tick), 32'd0);
      check("stopped.ratio", 32'(cur_ratio), 32'd8);
      step();
    end
    en = 1'b1;
    step();
    en = 1'b0;
    skip(5);
    en = 1'b1;
    skip(3);
    run_wave("rerun8", 8, 4, 1);

    // 5: coercion of 0 and 1 to 2
    skip(7);
    load_at(8'd0);
    run_wave("coerce0", 2, 1, 2);
    step();
    load_at(8'd1);
    run_wave("coerce1", 2, 1, 2);

    // 6: maximum ratio, then asynchronous reset mid-period
    step();
    load_at(8'd255);
    run_wave("div255", 255, 127, 1);
    skip(50);
    check("pre_rst.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.clk_out", 32'(clk_out), 32'd0);
    check("arst.tick", 32'(tick), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.ratio", 32'(cur_ratio), 32'd4);
    step();
    rst_n = 1'b1;
    step();
    run_wave("post_rst", 4, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, glitch-free clock divider and tick generator, successor to the team's fixed divide-by-4 block. From `clk` it produces a divided waveform `clk_out` and a one-cycle period-start strobe `tick`. The divide ratio can be changed at run time and takes effect only at period boundaries. It sits in the display/timing path and feeds scan and refresh logic. Its outputs are used as enables or as fabric-routed slow clocks.

## Interface
- `CNT_W`, default 8: width of the ratio and the internal counter; legal range ≥ 2.
- `DEFAULT_DIV`, default 4: reset value of the shadow and active ratios; must be ≥ 2 and < 2^CNT_W.

Clock and reset: reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input 1: run request.
- `div_ratio` input CNT_W: requested divide ratio N.
- `div_load` input 1: one-cycle strobe that captures `div_ratio` into the shadow register.
- `clk_out` output 1: divided clock, registered.
- `tick` output 1: high for exactly one cycle when each period begins, registered.
- `busy` output 1: high while a period is in progress.
- `cur_ratio` output CNT_W: ratio of the period currently running.

## Operation
- **Ratio coercion.**
  - A captured value below 2 (0 or 1) is stored as 2.
  - Coerced value: `cr = (div_ratio < 2) ? 2 : div_ratio`.
- **Shadow register.**
  - Updated from `cr` on every edge where `div_load` = 1.
  - Next-period value: `nxt = div_load ? cr : shadow`. A load in the same cycle as a period start therefore applies to that period.
- **Active ratio.**
  - `act` (driven on `cur_ratio`) is loaded only when a period starts.
- **High-phase length.**
  - `H = act >> 1`.
  - `clk_out` is high for H cycles, then low for `act − H` cycles.
  - Even N gives 50 % duty. Odd N has the low phase one cycle longer.
- **States.**
  - IDLE: `busy` = 0, `cnt` = 0.
  - RUN: `busy` = 1, `cnt` counts 0..act−1.
- **Transitions, on each rising edge.**
  - IDLE with `en` = 1 → RUN (period start).
  - RUN with `cnt` < act−1 → `cnt` += 1; `clk_out` ← (cnt+1 < H); `tick` ← 0.
  - RUN with `cnt` = act−1 and `en` = 1 → new period start.
  - RUN with `cnt` = act−1 and `en` = 0 → IDLE; `cnt` ← 0, `clk_out` ← 0, `tick` ← 0, `busy` ← 0.
- **Period start.**
  - `cnt` ← 0, `act` ← nxt, `clk_out` ← 1, `tick` ← 1, `busy` ← 1.
- **Disabling and re-enabling.**
  - Deasserting `en` never truncates a period. The current period always completes.
  - If `en` rises again before the wrap, periods continue with no gap.
- **Counter width.** `cnt` is CNT_W bits and never exceeds act−1, so it cannot overflow.

## Timing
- **Reset values.**
  - `clk_out` = 0, `tick` = 0, `busy` = 0, `cnt` = 0.
  - `cur_ratio` = `DEFAULT_DIV`; shadow = `DEFAULT_DIV`.
- **Start latency.** `en` sampled high at edge k → `clk_out`, `tick` and `busy` all go high after edge k (1 cycle).
- **Steady state.**
  - Period is exactly N clk cycles.
  - `tick` pulses once per period, coincident with `clk_out` rising.
- **Ratio change latency.** A new ratio takes effect at the first period start after the load. That is at most `act` cycles after the `div_load` edge, or immediately if it coincides with a start.
- **Multiple loads within one period.** Only the last one takes effect.
- **Stop latency.** After `en` falls, `busy` stays high until the end of the current period, then drops. `clk_out` is already low at that point, so there are no runt pulses.
- **Reset mid-operation.** All outputs return to their reset values asynchronously. The shadow value is lost and reverts to `DEFAULT_DIV`.
- **Glitch-free output.** `clk_out` has no high pulse shorter than H cycles and no low pulse shorter than `act − H` cycles, under any sequence of `div_load`/`en`.

## Test plan
1. Reset, then `en` = 1 with defaults: `clk_out` repeats 1,1,0,0 every 4 cycles; `tick` pulses on every 4th cycle; `cur_ratio` = 4; `busy` = 1.
2. Load `div_ratio` = 5 at the start of a period, then run: waveform is 1,1,0,0,0 with a 5-cycle `tick` spacing; load `div_ratio` = 2: waveform is 1,0 repeating.
3. Load `div_ratio` = 6 at `cnt` = 1 of an N = 4 period: the current period completes as 4 cycles, the next has high for 3 and low for 3, and `cur_ratio` changes at the boundary.
4. Deassert `en` at `cnt` = 0 with N = 8: `clk_out` completes 4 high, 4 low, then stays at 0; `busy` falls at the wrap; no further `tick`. Reassert `en` at `cnt` = 5 in a rerun: no gap between periods.
5. Load `div_ratio` = 0, then `div_ratio` = 1: `cur_ratio` reads 2 in both cases, giving `clk_out` 1,0.
6. With `CNT_W` = 8, load `div_ratio` = 255: 127 high, 128 low, `tick` every 255 cycles. Assert `rst_n` = 0 mid-period: all outputs are at reset values immediately, and `cur_ratio` = 4.
